lot_occupancy_counter: RTL and testbench

- Upstream stage of the lot HEX display. Watches the two gate photo-sensors (outer `a`, inner `b`) and decodes complete car entries and exits with a direction FSM.
- Maintains the saturating 5-bit occupancy count consumed by the display's `count` input.
- Also flags full/empty and emits one-cycle enter/exit event pulses for other consumers.

---
 rtl/lot_occupancy_counter.sv | 138 +++++++++++++
 tb/tb_lot_occupancy_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lot_occupancy_counter.sv
// rtl/lot_occupancy_counter.sv - gate direction FSM with saturating occupancy count and enter/exit pulses
// Optional macro LOT_SENSOR_SYNC_EN adds a two-flop synchronizer on each sensor.
module lot_occupancy_counter #(
   parameter int CAPACITY = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   output logic [4:0] count,
   output logic       enter,
   output logic       exit,
   output logic       full,
   output logic       empty
);

   generate
      if (CAPACITY > 31 || CAPACITY < 1) begin : g_bad_capacity
         $error("lot_occupancy_counter: CAPACITY must be in 1..31");
      end
   endgenerate

   localparam logic [4:0] CAP = 5'(CAPACITY);

   typedef enum logic [2:0] {
      CLEAR, IDLE, E1, E2, E3, X1, X2, X3
   } state_t;

   state_t     state, state_next;
   logic [1:0] ab;
   logic       fire_enter, fire_exit;

`ifdef LOT_SENSOR_SYNC_EN
   logic [1:0] a_sync, b_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sync <= 2'b00;
         b_sync <= 2'b00;
      end else begin
         a_sync <= {a_sync[0], a};
         b_sync <= {b_sync[0], b};
      end
   end

   assign ab = {a_sync[1], b_sync[1]};
`else
   assign ab = {a, b};
`endif

   // Any sensor pattern that skips a step parks the FSM in CLEAR until the gate is empty.
   always_comb begin
      state_next = state;
      fire_enter = 1'b0;
      fire_exit  = 1'b0;
      case (state)
         CLEAR: if (ab == 2'b00) state_next = IDLE;
         IDLE:
            case (ab)
               2'b10:   state_next = E1;
               2'b01:   state_next = X1;
               2'b11:   state_next = CLEAR;
               default: state_next = IDLE;
            endcase
         E1:
            case (ab)
               2'b11:   state_next = E2;
               2'b00:   state_next = IDLE;
               2'b01:   state_next = CLEAR;
               default: state_next = E1;
            endcase
         E2:
            case (ab)
               2'b01:   state_next = E3;
               2'b10:   state_next = E1;
               2'b00:   state_next = CLEAR;
               default: state_next = E2;
            endcase
         E3:
            case (ab)
               2'b00: begin
                  state_next = IDLE;
                  fire_enter = 1'b1;
               end
               2'b11:   state_next = E2;
               2'b10:   state_next = CLEAR;
               default: state_next = E3;
            endcase
         X1:
            case (ab)
               2'b11:   state_next = X2;
               2'b00:   state_next = IDLE;
               2'b10:   state_next = CLEAR;
               default: state_next = X1;
            endcase
         X2:
            case (ab)
               2'b10:   state_next = X3;
               2'b01:   state_next = X1;
               2'b00:   state_next = CLEAR;
               default: state_next = X2;
            endcase
         X3:
            case (ab)
               2'b00: begin
                  state_next = IDLE;
                  fire_exit  = 1'b1;
               end
               2'b11:   state_next = X2;
               2'b01:   state_next = CLEAR;
               default: state_next = X3;
            endcase
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         count <= 5'd0;
         enter <= 1'b0;
         exit  <= 1'b0;
      end else begin
         state <= state_next;
         enter <= fire_enter;
         exit  <= fire_exit;
         // Pulses fire even when saturated; only the count holds.
         if (fire_enter && count != CAP)
            count <= count + 5'd1;
         else if (fire_exit && count != 5'd0)
            count <= count - 5'd1;
      end
   end

   assign full  = (count == CAP);
   assign empty = (count == 5'd0);

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// tb/tb_lot_occupancy_counter.sv - directed scoreboard bench for lot_occupancy_counter
module tb_lot_occupancy_counter;

   localparam int CAP = 16;
   localparam int EV_NONE  = 0;
   localparam int EV_ENTER = 1;
   localparam int EV_EXIT  = 2;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic [4:0] count;
   logic       enter;
   logic       exit;
   logic       full;
   logic       empty;

   typedef struct {
      logic       enter;
      logic       exit;
      logic [4:0] count;
      logic       full;
      logic       empty;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_count = 0;

   lot_occupancy_counter #(.CAPACITY(CAP)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .count (count),
      .enter (enter),
      .exit  (exit),
      .full  (full),
      .empty (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_expect(input int ev, input string tag);
      exp_t e;
      if (ev == EV_ENTER && exp_count < CAP) exp_count++;
      if (ev == EV_EXIT && exp_count > 0) exp_count--;
      e.enter = (ev == EV_ENTER);
      e.exit  = (ev == EV_EXIT);
      e.count = 5'(exp_count);
      e.full  = (exp_count == CAP);
      e.empty = (exp_count == 0);
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic pop_compare();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      check({e.tag, "_enter"}, int'(enter), int'(e.enter));
      check({e.tag, "_exit"},  int'(exit),  int'(e.exit));
      check({e.tag, "_count"}, int'(count), int'(e.count));
      check({e.tag, "_full"},  int'(full),  int'(e.full));
      check({e.tag, "_empty"}, int'(empty), int'(e.empty));
   endtask

   // Hold {a,b} for n cycles; ev is the event expected on the edge that samples the first cycle.
   task automatic step(input logic [1:0] ab, input int n, input int ev, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b0;
         {a, b} = ab;
         push_expect((i == 0) ? ev : EV_NONE, tag);
         @(posedge clk);
         #1;
         pop_compare();
      end
   endtask

   task automatic do_reset(input logic [1:0] ab, input string tag);
      @(negedge clk);
      reset = 1'b1;
      {a, b} = ab;
      exp_count = 0;
      push_expect(EV_NONE, tag);
      @(posedge clk);
      #1;
      pop_compare();
   endtask

   task automatic entry(input string tag);
      step(2'b10, 2, EV_NONE, tag);
      step(2'b11, 2, EV_NONE, tag);
      step(2'b01, 2, EV_NONE, tag);
      step(2'b00, 2, EV_ENTER, tag);
   endtask

   task automatic exit_seq(input string tag);
      step(2'b01, 2, EV_NONE, tag);
      step(2'b11, 2, EV_NONE, tag);
      step(2'b10, 2, EV_NONE, tag);
      step(2'b00, 2, EV_EXIT, tag);
   endtask

   initial begin
      reset = 1'b1;
      a = 1'b0;
      b = 1'b0;
      do_reset(2'b00, "reset");
      step(2'b00, 2, EV_NONE, "idle");

      entry("entry1");
      exit_seq("exit1");
      exit_seq("exit_at_zero");

      for (int i = 0; i < 17; i++) entry($sformatf("fill%0d", i));

      step(2'b10, 2, EV_NONE, "backout");
      step(2'b11, 2, EV_NONE, "backout");
      step(2'b10, 2, EV_NONE, "backout");
      step(2'b00, 2, EV_NONE, "backout");

      step(2'b10, 2, EV_NONE, "stepback");
      step(2'b11, 2, EV_NONE, "stepback");
      step(2'b01, 2, EV_NONE, "stepback");
      step(2'b11, 2, EV_NONE, "stepback");
      step(2'b01, 2, EV_NONE, "stepback");
      step(2'b00, 2, EV_ENTER, "stepback");

      step(2'b11, 2, EV_NONE, "glitch_idle");
      step(2'b01, 2, EV_NONE, "glitch_idle");
      step(2'b00, 2, EV_NONE, "glitch_idle");
      step(2'b10, 2, EV_NONE, "glitch_e1");
      step(2'b01, 2, EV_NONE, "glitch_e1");
      step(2'b00, 2, EV_NONE, "glitch_e1");

      exit_seq("exit_from_full");

      step(2'b10, 2, EV_NONE, "rst_mid");
      step(2'b11, 2, EV_NONE, "rst_mid");
      step(2'b01, 2, EV_NONE, "rst_mid");
      do_reset(2'b01, "rst_mid_reset");
      step(2'b00, 3, EV_NONE, "rst_mid_after");
      entry("entry_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
